// File: rtl/router_pkg.sv
// Shared definitions for the 5-port mesh router: port count, direction encodings,
// port indices and the output-register FSM state type.
package router_pkg;

    localparam int NUM_PORTS = 5;
    localparam int PTR_W     = 3;

    localparam logic [NUM_PORTS-1:0] DIR_L  = 5'b10000;
    localparam logic [NUM_PORTS-1:0] DIR_R  = 5'b01000;
    localparam logic [NUM_PORTS-1:0] DIR_U  = 5'b00100;
    localparam logic [NUM_PORTS-1:0] DIR_D  = 5'b00010;
    localparam logic [NUM_PORTS-1:0] DIR_PE = 5'b00001;

    localparam int IDX_L  = 4;
    localparam int IDX_R  = 3;
    localparam int IDX_U  = 2;
    localparam int IDX_D  = 1;
    localparam int IDX_PE = 0;

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: the first set request at or above ptr
// (wrapping modulo NUM_PORTS) wins.
module rr_arbiter
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  ptr_t                 ptr,
    output logic [NUM_PORTS-1:0] win,
    output ptr_t                 win_idx,
    output logic                 found
);

    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(ptr) + k) % NUM_PORTS;
            if (!found && req[idx]) begin
                found      = 1'b1;
                win[idx]   = 1'b1;
                win_idx    = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Per-output-direction round-robin arbiter with a single-entry output register.
// Optional granted-flit counter port pkt_cnt is enabled by OUTPUT_ARBITER_STATS_EN.
module output_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PORTS  = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] datai,
    input  logic                            ro,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            so,
    output logic [DATA_WIDTH-1:0]           datao
`ifdef OUTPUT_ARBITER_STATS_EN
    ,
    output logic [15:0]                     pkt_cnt
`endif
);
    import router_pkg::*;

    state_t                  state, state_next;
    ptr_t                    ptr, ptr_next, win_idx;
    logic [NUM_PORTS-1:0]    win;
    logic                    found;
    logic                    accept;
    logic                    load;
    logic [DATA_WIDTH-1:0]   data_mux;
    logic [DATA_WIDTH-1:0]   data_p0;

    rr_arbiter u_rr (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .found   (found)
    );

    always_comb begin
        accept     = (state == EMPTY) || ((state == FULL) && ro);
        load       = accept && found && !rst;
        grant      = load ? win : '0;
        state_next = state;
        ptr_next   = ptr;
        if (accept) begin
            state_next = found ? FULL : EMPTY;
        end
        if (load) begin
            ptr_next = (win_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (win[i]) data_mux = datai[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            ptr   <= ptr_t'(IDX_PE);
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Output register stage: loaded only on a grant, otherwise holds the last flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p0 <= '0;
        end else if (load) begin
            data_p0 <= data_mux;
        end
    end

    assign so    = (state == FULL);
    assign datao = data_p0;

`ifdef OUTPUT_ARBITER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if ((|grant) && (pkt_cnt != 16'hFFFF)) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_output_arbiter.sv
// Bench for output_arbiter: vector table with a datao scoreboard, plus
// hand-written async-reset and (optionally) counter-saturation sequences.
module tb_output_arbiter;

    localparam int DW = 64;
    localparam int NP = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NP-1:0]      req = '0;
    logic [NP*DW-1:0]   datai = '0;
    logic               ro = 1'b0;
    logic [NP-1:0]      grant;
    logic               so;
    logic [DW-1:0]      datao;
`ifdef OUTPUT_ARBITER_STATS_EN
    logic [15:0]        pkt_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] last_exp = '0;

    output_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .datai   (datai),
        .ro      (ro),
        .grant   (grant),
        .so      (so),
        .datao   (datao)
`ifdef OUTPUT_ARBITER_STATS_EN
        ,
        .pkt_cnt (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_first;
        logic [NP-1:0] req;
        logic          ro;
        logic [NP-1:0] exp_grant;
        logic          exp_so;
    } vec_t;

    vec_t vt[20];

    function automatic logic [DW-1:0] slice_val(input int v, input int i);
        return 64'hA5 | (64'(v) << 16) | (64'(i) << 8);
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_data(input int v);
        for (int i = 0; i < NP; i++) datai[i*DW +: DW] = slice_val(v, i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        #1;
        chk("grant_in_reset", 64'(grant), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        last_exp = '0;
    endtask

    task automatic apply(input int v, input logic [NP-1:0] r, input logic ro_v,
                         input logic [NP-1:0] eg, input logic es);
        logic [DW-1:0] exp_d;
        @(negedge clk);
        req = r;
        ro  = ro_v;
        load_data(v);
        #1;
        chk($sformatf("grant_v%0d", v), 64'(grant), 64'(eg));
        for (int i = 0; i < NP; i++) if (eg[i]) sb.push_back(slice_val(v, i));
        @(posedge clk);
        #1;
        chk($sformatf("so_v%0d", v), 64'(so), 64'(es));
        if (sb.size() > 0) begin
            exp_d    = sb.pop_front();
            last_exp = exp_d;
            chk($sformatf("datao_v%0d", v), datao, exp_d);
        end else if (es) begin
            chk($sformatf("datao_hold_v%0d", v), datao, last_exp);
        end
    endtask

    initial begin
        // rst_first, req, ro, expected grant, expected so after the edge
        vt[0]  = '{1'b0, 5'b00001, 1'b0, 5'b00001, 1'b1};
        vt[1]  = '{1'b0, 5'b00000, 1'b0, 5'b00000, 1'b1};
        vt[2]  = '{1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0};
        vt[3]  = '{1'b1, 5'b11111, 1'b1, 5'b00001, 1'b1};
        vt[4]  = '{1'b0, 5'b11111, 1'b1, 5'b00010, 1'b1};
        vt[5]  = '{1'b0, 5'b11111, 1'b1, 5'b00100, 1'b1};
        vt[6]  = '{1'b0, 5'b11111, 1'b1, 5'b01000, 1'b1};
        vt[7]  = '{1'b0, 5'b11111, 1'b1, 5'b10000, 1'b1};
        vt[8]  = '{1'b0, 5'b11111, 1'b1, 5'b00001, 1'b1};
        vt[9]  = '{1'b0, 5'b10000, 1'b0, 5'b00000, 1'b1};
        vt[10] = '{1'b0, 5'b10000, 1'b0, 5'b00000, 1'b1};
        vt[11] = '{1'b0, 5'b10000, 1'b0, 5'b00000, 1'b1};
        vt[12] = '{1'b0, 5'b10000, 1'b1, 5'b10000, 1'b1};
        vt[13] = '{1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0};
        vt[14] = '{1'b0, 5'b00010, 1'b1, 5'b00010, 1'b1};
        vt[15] = '{1'b0, 5'b01010, 1'b1, 5'b01000, 1'b1};
        vt[16] = '{1'b0, 5'b01010, 1'b1, 5'b00010, 1'b1};
        vt[17] = '{1'b0, 5'b00000, 1'b0, 5'b00000, 1'b1};
        vt[18] = '{1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0};
        vt[19] = '{1'b0, 5'b00100, 1'b0, 5'b00100, 1'b1};

        // Reset state
        #2;
        chk("rst_so", 64'(so), 64'(0));
        chk("rst_datao", datao, 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_so", 64'(so), 64'(0));

        for (int v = 0; v < 20; v++) begin
            if (vt[v].rst_first) do_reset();
            apply(v, vt[v].req, vt[v].ro, vt[v].exp_grant, vt[v].exp_so);
        end

        // Asynchronous reset mid-cycle while FULL with ptr=3
        @(negedge clk);
        req = 5'b11111;
        ro  = 1'b1;
        load_data(30);
        #1;
        chk("pre_rst_grant", 64'(grant), 64'(5'b01000));
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_so", 64'(so), 64'(0));
        chk("async_rst_datao", datao, 64'(0));
        chk("async_rst_grant", 64'(grant), 64'(0));
        @(posedge clk);
        #1;
        chk("rst_held_grant", 64'(grant), 64'(0));
        chk("rst_held_so", 64'(so), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        load_data(31);
        #1;
        chk("post_rst_grant_ptr0", 64'(grant), 64'(5'b00001));
        @(posedge clk);
        #1;
        chk("post_rst_so", 64'(so), 64'(1));
        chk("post_rst_datao", datao, slice_val(31, 0));

`ifdef OUTPUT_ARBITER_STATS_EN
        do_reset();
        #1;
        chk("cnt_reset", 64'(pkt_cnt), 64'(0));
        @(negedge clk);
        req = 5'b11111;
        ro  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_three", 64'(pkt_cnt), 64'(3));
        repeat (70000) @(posedge clk);
        #1;
        chk("cnt_saturate", 64'(pkt_cnt), 64'(16'hFFFF));
        repeat (5) @(posedge clk);
        #1;
        chk("cnt_hold", 64'(pkt_cnt), 64'(16'hFFFF));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_arbiter.md
# output_arbiter

Per-output-port arbiter and single-entry output register for the 5-port mesh router. One instance sits on each output direction (L, R, U, D, PE) and collects the matching request bit and data from all five `input_interface` instances. It selects one requester round-robin and pulses that input's buffer-clear line. It then presents the winning flit downstream with a send/ready handshake.

## Interface
- `DATA_WIDTH`, 64, flit width.
- `NUM_PORTS`, 5, number of requesters. Only 5 is supported. Index 4=L, 3=R, 2=U, 1=D, 0=PE.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NUM_PORTS  request bit i comes from input i for this output direction.
- `datai`  in  NUM_PORTS*DATA_WIDTH  slice [i*DATA_WIDTH +: DATA_WIDTH] is input i's flit.
- `ro`  in  1  downstream ready to accept.
- `grant`  out  NUM_PORTS  one-hot, one cycle wide; drives buffer-clear of input i.
- `so`  out  1  output register holds a valid flit.
- `datao`  out  DATA_WIDTH  flit presented downstream.
- `pkt_cnt`  out  16  granted-flit count. Present only with `OUTPUT_ARBITER_STATS_EN`.

## Operation
- FSM states:
  - EMPTY (so=0).
  - FULL (so=1).
- accept = (state==EMPTY) | (state==FULL & ro). accept is combinational.
- Arbitration:
  - Search req from index ptr upward, mod 5.
  - The first set bit wins. Call it w.
  - If no req is set, there is no winner.
- When accept and a winner exists:
  - grant[w]=1 this cycle.
  - datao <= datai slice w.
  - state <= FULL.
  - ptr <= (w+1) mod 5.
- When accept and no winner:
  - FULL with ro: flit drained, state <= EMPTY, datao holds its last value.
  - EMPTY: remain EMPTY.
- FULL & !ro: hold datao and so. grant=0. Requests wait. ptr is unchanged.
- ptr changes only on a grant. Requests with no grant never move ptr.
- grant is never asserted when accept=0 or during rst.
- Simultaneous drain and refill (FULL, ro=1, req≠0): the new flit is loaded and so stays 1. Sustained rate is 1 flit/cycle.
- A request held by the same input through its grant cycle is consumed once. The input must deassert req in the cycle after grant, because its buffer is cleared on that edge.

## Timing
- Reset values: state=EMPTY, so=0, datao=0, ptr=0 (PE highest priority), grant=0, pkt_cnt=0.
- Asserting rst mid-transfer drops the held flit immediately (asynchronous). No grant is issued while rst=1.
- Latency:
  - req high in cycle N with accept → grant in cycle N (combinational).
  - so and datao are valid from cycle N+1.
- A downstream transfer happens on any edge where so=1 and ro=1.
- `ro` is a don't-care while so=0.
- Worst-case wait for a continuously requesting input is 4 grants.

## Configuration
- `OUTPUT_ARBITER_STATS_EN` defined:
  - Adds port `pkt_cnt`, a 16-bit counter.
  - Increments on every cycle in which grant≠0.
  - Saturates at 0xFFFF.
  - Cleared by rst.
- Not defined: the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package `router_pkg`:
  - `NUM_PORTS`.
  - Direction one-hot encodings (L=5'b10000, R=5'b01000, U=5'b00100, D=5'b00010, PE=5'b00001).
  - Port index constants (IDX_L=4 … IDX_PE=0).
  - FSM state typedef.
- Sub-module `rr_arbiter` (combinational):
  - Inputs: req, ptr.
  - Outputs: one-hot win and encoded index.
  - Enable is gated by accept in `output_arbiter`.
- Data mux, output register, FSM and ptr are in the top.

## Test plan
- Reset, then req=5'b00001, datai[0]=64'hA5 → grant=5'b00001 in the same cycle. Next cycle so=1, datao=64'hA5, ptr=1.
- All five req held, ro=1 continuously, from reset → grant sequence PE, D, U, R, L, PE. One flit per cycle, so stays 1.
- FULL with ro=0 for 3 cycles while req=5'b10000 → grant=0, datao stable. The cycle ro rises, grant=5'b10000 and datao updates on the next edge.
- req=5'b01010 with ptr=2 → D (index 1) is skipped and R (index 3) wins, ptr=4. Next winner is D.
- FULL, rst pulsed asynchronously mid-cycle → so=0, datao=0, ptr=0 immediately. No grant during rst.
- `OUTPUT_ARBITER_STATS_EN`: 70000 consecutive grants → pkt_cnt=16'hFFFF, and it holds.
